// File: rtl/jellyvl_synctimer_adjust_arbiter.sv
// jellyvl_synctimer_adjust_arbiter: nets per-source adjust pulses and issues them round-robin onto one timer port
// Define JELLYVL_SYNCTIMER_ADJUST_ARBITER_STAT_EN to add per-source issued-pulse net counters (stat_net).
module jellyvl_synctimer_adjust_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int PEND_WIDTH = 8,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [GAP_WIDTH-1:0]   gap_cycles,
  input  logic [NUM_PORTS-1:0]   s_adjust_sign,
  input  logic [NUM_PORTS-1:0]   s_adjust_valid,
  output logic [NUM_PORTS-1:0]   s_adjust_ready,
  output logic                   m_adjust_sign,
  output logic                   m_adjust_valid,
  input  logic                   m_adjust_ready,
  output logic                   busy
`ifdef JELLYVL_SYNCTIMER_ADJUST_ARBITER_STAT_EN
  ,
  output logic [NUM_PORTS*32-1:0] stat_net
`endif
);
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  typedef logic signed [PEND_WIDTH-1:0] pend_t;
  localparam pend_t PEND_MAX = {1'b0, {(PEND_WIDTH-1){1'b1}}};
  localparam pend_t PEND_MIN = {1'b1, {(PEND_WIDTH-1){1'b0}}};
  localparam pend_t ONE = pend_t'(1);
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
  state_t state, state_next;
  pend_t pend [NUM_PORTS];
  pend_t pend_next [NUM_PORTS];
  logic [IW-1:0] rr, rr_next, gnt;
  logic [GAP_WIDTH-1:0] cnt, cnt_next;
  logic valid_next, sign_next, found, gsign, grant;
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++)
      s_adjust_ready[i] = rst && pend[i] != PEND_MAX && pend[i] != PEND_MIN;
  end
  always_comb begin
    busy = state != IDLE;
    for (int i = 0; i < NUM_PORTS; i++)
      if (pend[i] != '0) busy = 1'b1;
  end
  // first nonzero source at or after rr, then wrap to those below rr
  always_comb begin
    found = 1'b0;
    gnt = '0;
    gsign = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (!found && i >= int'(rr) && pend[i] != '0) begin
        found = 1'b1;
        gnt = IW'(i);
        gsign = pend[i][PEND_WIDTH-1];
      end
    for (int i = 0; i < NUM_PORTS; i++)
      if (!found && i < int'(rr) && pend[i] != '0) begin
        found = 1'b1;
        gnt = IW'(i);
        gsign = pend[i][PEND_WIDTH-1];
      end
  end
  assign grant = state == IDLE && enable && !clear && found;
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++)
      pend_next[i] = clear ? '0 : pend[i]
        + ((s_adjust_valid[i] && s_adjust_ready[i]) ? (s_adjust_sign[i] ? -ONE : ONE) : '0)
        - ((grant && gnt == IW'(i)) ? (pend[i][PEND_WIDTH-1] ? -ONE : ONE) : '0);
  end
  always_comb begin
    state_next = state;
    rr_next = rr;
    cnt_next = cnt;
    valid_next = m_adjust_valid;
    sign_next = m_adjust_sign;
    case (state)
      IDLE: if (grant) begin
        state_next = ISSUE;
        valid_next = 1'b1;
        sign_next = gsign;
        rr_next = (gnt == IW'(NUM_PORTS - 1)) ? '0 : gnt + 1'b1;
      end
      ISSUE: if (m_adjust_ready) begin
        valid_next = 1'b0;
        state_next = (gap_cycles != '0) ? GAP : IDLE;
        cnt_next = gap_cycles;
      end
      GAP: begin
        cnt_next = cnt - 1'b1;
        state_next = (cnt == GAP_WIDTH'(1)) ? IDLE : GAP;
      end
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rr <= '0;
      cnt <= '0;
      m_adjust_valid <= 1'b0;
      m_adjust_sign <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) pend[i] <= '0;
    end else begin
      state <= state_next;
      rr <= rr_next;
      cnt <= cnt_next;
      m_adjust_valid <= valid_next;
      m_adjust_sign <= sign_next;
      for (int i = 0; i < NUM_PORTS; i++) pend[i] <= pend_next[i];
    end
  end
`ifdef JELLYVL_SYNCTIMER_ADJUST_ARBITER_STAT_EN
  logic [IW-1:0] sel;
  logic [31:0] stat [NUM_PORTS];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel <= '0;
      for (int i = 0; i < NUM_PORTS; i++) stat[i] <= '0;
    end else begin
      if (grant) sel <= gnt;
      for (int i = 0; i < NUM_PORTS; i++)
        if (clear) stat[i] <= '0;
        else if (state == ISSUE && m_adjust_valid && m_adjust_ready && sel == IW'(i))
          stat[i] <= stat[i] + (m_adjust_sign ? 32'hffff_ffff : 32'd1);
    end
  end
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_stat
    assign stat_net[g*32 +: 32] = stat[g];
  end
`endif
endmodule

// File: tb/tb_jellyvl_synctimer_adjust_arbiter.sv
// tb_jellyvl_synctimer_adjust_arbiter: directed scenarios for the adjust-pulse arbiter
// Built with PEND_WIDTH=4 so the saturation limit (+7) is reachable quickly.
module tb_jellyvl_synctimer_adjust_arbiter;
  logic clk = 1'b0;
  logic rst, enable, clear, m_adjust_ready, m_adjust_sign, m_adjust_valid, busy;
  logic [7:0] gap_cycles;
  logic [1:0] s_adjust_sign, s_adjust_valid, s_adjust_ready;
  int vectors = 0;
  int miscompares = 0;
  logic q[$];

  jellyvl_synctimer_adjust_arbiter #(.NUM_PORTS(2), .PEND_WIDTH(4), .GAP_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .gap_cycles(gap_cycles),
    .s_adjust_sign(s_adjust_sign), .s_adjust_valid(s_adjust_valid), .s_adjust_ready(s_adjust_ready),
    .m_adjust_sign(m_adjust_sign), .m_adjust_valid(m_adjust_valid), .m_adjust_ready(m_adjust_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // inputs only change 1 time unit after posedge, so the negedge view matches the next edge
  always @(negedge clk)
    if (rst && m_adjust_valid && m_adjust_ready) q.push_back(m_adjust_sign);

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    rst = 1'b0; enable = 1'b0; clear = 1'b0; gap_cycles = 8'd0;
    s_adjust_sign = 2'b00; s_adjust_valid = 2'b00; m_adjust_ready = 1'b0;
    tick(2);
    rst = 1'b1;
    q.delete();
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!m_adjust_valid && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (m_adjust_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: m_adjust_valid timeout got %b want 1", name, m_adjust_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; enable = 1'b1; clear = 1'b0; gap_cycles = 8'd0;
    s_adjust_sign = 2'b00; s_adjust_valid = 2'b11; m_adjust_ready = 1'b1;
    tick(2);
    vectors++; if (m_adjust_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", m_adjust_valid); end
    vectors++; if (m_adjust_sign !== 1'b0) begin miscompares++; $display("FAIL reset_sign: got %b want 0", m_adjust_sign); end
    vectors++; if (s_adjust_ready !== 2'b00) begin miscompares++; $display("FAIL reset_ready: got %b want 00", s_adjust_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    do_reset();
    #1;
    vectors++; if (s_adjust_ready !== 2'b11) begin miscompares++; $display("FAIL release_ready: got %b want 11", s_adjust_ready); end
  endtask

  task automatic test_basic;
    enable = 1'b1; m_adjust_ready = 1'b1; gap_cycles = 8'd0;
    s_adjust_sign = 2'b00; s_adjust_valid = 2'b01;
    tick();
    vectors++; if (m_adjust_valid !== 1'b0) begin miscompares++; $display("FAIL basic_lat1: got %b want 0", m_adjust_valid); end
    tick();
    vectors++; if (m_adjust_valid !== 1'b1) begin miscompares++; $display("FAIL basic_lat2: got %b want 1", m_adjust_valid); end
    tick();
    s_adjust_valid = 2'b00;
    tick(8);
    vectors++; if (q.size() !== 3) begin miscompares++; $display("FAIL basic_count: got %0d want 3", q.size()); end
    foreach (q[i]) begin
      vectors++; if (q[i] !== 1'b0) begin miscompares++; $display("FAIL basic_sign%0d: got %b want 0", i, q[i]); end
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy: got %b want 0", busy); end
  endtask

  task automatic test_netting;
    q.delete();
    enable = 1'b0; s_adjust_valid = 2'b01; s_adjust_sign = 2'b00;
    tick();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL net_busy_pend: got %b want 1", busy); end
    s_adjust_sign = 2'b01;
    tick();
    s_adjust_valid = 2'b00;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL net_busy_zero: got %b want 0", busy); end
    enable = 1'b1;
    tick(5);
    vectors++; if (q.size() !== 0) begin miscompares++; $display("FAIL net_pulses: got %0d want 0", q.size()); end
    vectors++; if (m_adjust_valid !== 1'b0) begin miscompares++; $display("FAIL net_valid: got %b want 0", m_adjust_valid); end
  endtask

  task automatic test_round_robin;
    do_reset();
    enable = 1'b1; m_adjust_ready = 1'b1; gap_cycles = 8'd0;
    s_adjust_sign = 2'b10; s_adjust_valid = 2'b11;
    tick(4);
    s_adjust_valid = 2'b00;
    tick(20);
    vectors++; if (q.size() !== 8) begin miscompares++; $display("FAIL rr_count: got %0d want 8", q.size()); end
    foreach (q[i]) begin
      vectors++; if (q[i] !== 1'(i % 2)) begin miscompares++; $display("FAIL rr_sign%0d: got %b want %b", i, q[i], 1'(i % 2)); end
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rr_busy: got %b want 0", busy); end
  endtask

  task automatic test_saturation;
    q.delete();
    enable = 1'b0; m_adjust_ready = 1'b1;
    s_adjust_sign = 2'b00; s_adjust_valid = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 6) begin
        vectors++; if (s_adjust_ready !== 2'b11) begin miscompares++; $display("FAIL sat_ready6: got %b want 11", s_adjust_ready); end
      end
      if (k >= 7) begin
        vectors++; if (s_adjust_ready !== 2'b10) begin miscompares++; $display("FAIL sat_ready%0d: got %b want 10", k, s_adjust_ready); end
      end
    end
    s_adjust_valid = 2'b00;
    enable = 1'b1;
    tick(20);
    vectors++; if (q.size() !== 7) begin miscompares++; $display("FAIL sat_count: got %0d want 7", q.size()); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL sat_busy: got %b want 0", busy); end
  endtask

  task automatic test_gap;
    q.delete();
    enable = 1'b0; m_adjust_ready = 1'b0; gap_cycles = 8'd3;
    s_adjust_sign = 2'b01; s_adjust_valid = 2'b01;
    tick(2);
    s_adjust_valid = 2'b00;
    enable = 1'b1;
    wait_valid("gap_first");
    for (int k = 0; k < 5; k++) begin
      vectors++; if ({m_adjust_valid, m_adjust_sign} !== 2'b11) begin miscompares++; $display("FAIL gap_hold%0d: got %b want 11", k, {m_adjust_valid, m_adjust_sign}); end
      if (k < 4) tick();
    end
    m_adjust_ready = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      vectors++; if (m_adjust_valid !== 1'b0) begin miscompares++; $display("FAIL gap_idle%0d: got %b want 0", k, m_adjust_valid); end
      tick();
    end
    vectors++; if (m_adjust_valid !== 1'b1) begin miscompares++; $display("FAIL gap_next: got %b want 1", m_adjust_valid); end
    tick(10);
    vectors++; if (q.size() !== 2) begin miscompares++; $display("FAIL gap_count: got %0d want 2", q.size()); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL gap_busy: got %b want 0", busy); end
  endtask

  task automatic test_clear_and_reset;
    q.delete();
    enable = 1'b0; m_adjust_ready = 1'b0; gap_cycles = 8'd0;
    s_adjust_sign = 2'b00; s_adjust_valid = 2'b01;
    tick(6);
    s_adjust_valid = 2'b00;
    enable = 1'b1;
    wait_valid("clr_first");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    vectors++; if ({busy, m_adjust_valid} !== 2'b11) begin miscompares++; $display("FAIL clr_inflight: got %b want 11", {busy, m_adjust_valid}); end
    m_adjust_ready = 1'b1;
    tick();
    vectors++; if (m_adjust_valid !== 1'b0) begin miscompares++; $display("FAIL clr_done: got %b want 0", m_adjust_valid); end
    tick(3);
    vectors++; if (q.size() !== 1) begin miscompares++; $display("FAIL clr_count: got %0d want 1", q.size()); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL clr_busy: got %b want 0", busy); end
    gap_cycles = 8'd5;
    s_adjust_sign = 2'b01; s_adjust_valid = 2'b01;
    tick();
    s_adjust_valid = 2'b00;
    tick();
    vectors++; if ({m_adjust_valid, m_adjust_sign} !== 2'b11) begin miscompares++; $display("FAIL rst_issue: got %b want 11", {m_adjust_valid, m_adjust_sign}); end
    tick();
    enable = 1'b0; s_adjust_valid = 2'b01;
    tick();
    s_adjust_valid = 2'b00;
    vectors++; if ({busy, m_adjust_valid, m_adjust_sign} !== 3'b101) begin miscompares++; $display("FAIL rst_gap: got %b want 101", {busy, m_adjust_valid, m_adjust_sign}); end
    #2 rst = 1'b0;
    #1;
    vectors++; if ({m_adjust_valid, m_adjust_sign, busy} !== 3'b000) begin miscompares++; $display("FAIL rst_async_out: got %b want 000", {m_adjust_valid, m_adjust_sign, busy}); end
    vectors++; if (s_adjust_ready !== 2'b00) begin miscompares++; $display("FAIL rst_async_ready: got %b want 00", s_adjust_ready); end
    tick();
    rst = 1'b1;
    tick(3);
    vectors++; if ({busy, m_adjust_valid} !== 2'b00) begin miscompares++; $display("FAIL rst_after: got %b want 00", {busy, m_adjust_valid}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_netting();
    test_round_robin();
    test_saturation();
    test_gap();
    test_clear_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
